ravenoc_pkt_tx: RTL and testbench

Packetizer that sits between a processing element and a router local input port. It accepts one message descriptor (destination, length, virtual channel) and a payload word stream. It emits a head flit followed by body/tail flits using the valid/ready flit handshake that the NoC local ports consume. It is the transmit-side counterpart of the mesh fabric's local receive path.

---
 rtl/ravenoc_pkg.sv | 33 +++
 rtl/ravenoc_flit_reg.sv | 31 +++
 rtl/ravenoc_pkt_tx.sv | 116 +++++++++++
 tb/tb_ravenoc_pkt_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// Shared NoC widths, flit type encoding, head-flit layout and packetizer states.
package ravenoc_pkg;

  localparam int unsigned FLIT_WIDTH   = 34;
  localparam int unsigned VC_WIDTH     = 2;
  localparam int unsigned PKT_WIDTH    = 8;
  localparam int unsigned NOC_CFG_SZ_X = 4;
  localparam int unsigned NOC_CFG_SZ_Y = 4;
  localparam int unsigned X_WIDTH = (NOC_CFG_SZ_X > 1) ? $clog2(NOC_CFG_SZ_X) : 1;
  localparam int unsigned Y_WIDTH = (NOC_CFG_SZ_Y > 1) ? $clog2(NOC_CFG_SZ_Y) : 1;
  localparam int unsigned HEAD_PAD_WIDTH = FLIT_WIDTH - 2 - X_WIDTH - Y_WIDTH - PKT_WIDTH;

  typedef enum logic [1:0] {
    HEAD_FLIT      = 2'b00,
    BODY_FLIT      = 2'b01,
    TAIL_FLIT      = 2'b10,
    HEAD_TAIL_FLIT = 2'b11
  } flit_type_t;

  typedef struct packed {
    flit_type_t                flit_type;
    logic [X_WIDTH-1:0]        x_dest;
    logic [Y_WIDTH-1:0]        y_dest;
    logic [PKT_WIDTH-1:0]      pkt_len;
    logic [HEAD_PAD_WIDTH-1:0] rsvd;
  } s_flit_head_data_t;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } pkt_tx_st_t;

endpackage

// File: rtl/ravenoc_flit_reg.sv
// Output flit register: loads a flit, holds it while stalled, drops valid once consumed.
module ravenoc_flit_reg #(
  parameter int unsigned FLIT_WIDTH = ravenoc_pkg::FLIT_WIDTH,
  parameter int unsigned VC_WIDTH   = ravenoc_pkg::VC_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  load,
  input  logic                  ready,
  input  logic [FLIT_WIDTH-1:0] next_data,
  input  logic [VC_WIDTH-1:0]   next_vc,
  output logic                  valid,
  output logic [FLIT_WIDTH-1:0] data,
  output logic [VC_WIDTH-1:0]   vc
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid <= 1'b0;
      data  <= '0;
      vc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= next_data;
      vc    <= next_vc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ravenoc_pkt_tx.sv
// Packetizer: descriptor + payload stream -> head/body/tail flits for a router local port.
// Define RAVENOC_PKT_TX_CNT_EN to add the pkt_cnt_o sent-packet counter.
module ravenoc_pkt_tx
  import ravenoc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = ravenoc_pkg::FLIT_WIDTH,
  parameter int unsigned VC_WIDTH   = ravenoc_pkg::VC_WIDTH,
  parameter int unsigned PKT_WIDTH  = ravenoc_pkg::PKT_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  msg_valid_i,
  output logic                  msg_ready_o,
  input  logic [X_WIDTH-1:0]    msg_x_dest_i,
  input  logic [Y_WIDTH-1:0]    msg_y_dest_i,
  input  logic [PKT_WIDTH-1:0]  msg_len_i,
  input  logic [VC_WIDTH-1:0]   msg_vc_i,
  input  logic                  pld_valid_i,
  output logic                  pld_ready_o,
  input  logic [FLIT_WIDTH-3:0] pld_data_i,
  output logic [FLIT_WIDTH-1:0] flit_data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
`ifdef RAVENOC_PKT_TX_CNT_EN
  output logic [31:0]           pkt_cnt_o,
`endif
  output logic [VC_WIDTH-1:0]   vc_id_o
);

  localparam int unsigned PAD_WIDTH = FLIT_WIDTH - 2 - X_WIDTH - Y_WIDTH - PKT_WIDTH;

  pkt_tx_st_t             state;
  logic [PKT_WIDTH-1:0]   remaining;
  logic [VC_WIDTH-1:0]    vc_q;
  logic                   out_free;
  logic                   msg_fire;
  logic                   pld_fire;
  logic                   load;
  flit_type_t             head_type;
  flit_type_t             body_type;
  logic [FLIT_WIDTH-1:0]  next_flit;
  logic [VC_WIDTH-1:0]    next_vc;

  // Readies depend only on state and output-register occupancy, never on source valids.
  always_comb begin
    out_free    = !valid_o || ready_i;
    msg_ready_o = (state == IDLE) && out_free;
    pld_ready_o = (state == BODY) && out_free;
    msg_fire    = msg_valid_i && msg_ready_o;
    pld_fire    = pld_valid_i && pld_ready_o;
    load        = msg_fire || pld_fire;
    head_type   = (msg_len_i == '0) ? HEAD_TAIL_FLIT : HEAD_FLIT;
    body_type   = (remaining == PKT_WIDTH'(1)) ? TAIL_FLIT : BODY_FLIT;
    if (msg_fire) begin
      next_flit = {head_type, msg_x_dest_i, msg_y_dest_i, msg_len_i, {PAD_WIDTH{1'b0}}};
      next_vc   = msg_vc_i;
    end else begin
      next_flit = {body_type, pld_data_i};
      next_vc   = vc_q;
    end
  end

  // Packet sequencing: remaining counts payload flits still owed after the head.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      remaining <= '0;
      vc_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (msg_fire) begin
            vc_q <= msg_vc_i;
            if (msg_len_i != '0) begin
              remaining <= msg_len_i;
              state     <= BODY;
            end
          end
        end
        BODY: begin
          if (pld_fire) begin
            remaining <= remaining - PKT_WIDTH'(1);
            if (remaining == PKT_WIDTH'(1)) state <= IDLE;
          end
        end
      endcase
    end
  end

  ravenoc_flit_reg #(
    .FLIT_WIDTH(FLIT_WIDTH),
    .VC_WIDTH  (VC_WIDTH)
  ) u_flit_reg (
    .clk      (clk),
    .arst     (arst),
    .load     (load),
    .ready    (ready_i),
    .next_data(next_flit),
    .next_vc  (next_vc),
    .valid    (valid_o),
    .data     (flit_data_o),
    .vc       (vc_id_o)
  );

`ifdef RAVENOC_PKT_TX_CNT_EN
  // Tail and head-tail encodings share a set MSB, so it marks the last flit of a packet.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pkt_cnt_o <= '0;
    end else if (valid_o && ready_i && flit_data_o[FLIT_WIDTH-1]) begin
      pkt_cnt_o <= pkt_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ravenoc_pkt_tx.sv
// Directed bench for ravenoc_pkt_tx with a flit scoreboard fed at stimulus time.
module tb_ravenoc_pkt_tx;
  import ravenoc_pkg::*;

  localparam int unsigned FW = FLIT_WIDTH;

  logic                 clk = 1'b0;
  logic                 arst;
  logic                 msg_valid_i;
  logic                 msg_ready_o;
  logic [X_WIDTH-1:0]   msg_x_dest_i;
  logic [Y_WIDTH-1:0]   msg_y_dest_i;
  logic [PKT_WIDTH-1:0] msg_len_i;
  logic [VC_WIDTH-1:0]  msg_vc_i;
  logic                 pld_valid_i;
  logic                 pld_ready_o;
  logic [FW-3:0]        pld_data_i;
  logic [FW-1:0]        flit_data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [VC_WIDTH-1:0]  vc_id_o;
`ifdef RAVENOC_PKT_TX_CNT_EN
  logic [31:0]          pkt_cnt_o;
`endif

  ravenoc_pkt_tx dut (
    .clk         (clk),
    .arst        (arst),
    .msg_valid_i (msg_valid_i),
    .msg_ready_o (msg_ready_o),
    .msg_x_dest_i(msg_x_dest_i),
    .msg_y_dest_i(msg_y_dest_i),
    .msg_len_i   (msg_len_i),
    .msg_vc_i    (msg_vc_i),
    .pld_valid_i (pld_valid_i),
    .pld_ready_o (pld_ready_o),
    .pld_data_i  (pld_data_i),
    .flit_data_o (flit_data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
`ifdef RAVENOC_PKT_TX_CNT_EN
    .pkt_cnt_o   (pkt_cnt_o),
`endif
    .vc_id_o     (vc_id_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0]       data;
    logic [VC_WIDTH-1:0] vc;
  } exp_t;

  exp_t                exp_q[$];
  int                  hs_cyc[$];
  int                  checks = 0;
  int                  errors = 0;
  int                  cyc = 0;
  logic [VC_WIDTH-1:0] cur_vc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [FW-1:0] mk_head(input logic [X_WIDTH-1:0] x,
                                            input logic [Y_WIDTH-1:0] y,
                                            input logic [PKT_WIDTH-1:0] len);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1:FW-2] = (len == '0) ? 2'b11 : 2'b00;
    f[FW-3 -: X_WIDTH] = x;
    f[FW-3-X_WIDTH -: Y_WIDTH] = y;
    f[FW-3-X_WIDTH-Y_WIDTH -: PKT_WIDTH] = len;
    return f;
  endfunction

  function automatic logic [FW-1:0] mk_body(input logic [1:0] t, input logic [FW-3:0] d);
    return {t, d};
  endfunction

  // Scoreboard: every flit handshake must match the oldest expected flit.
  always @(negedge clk) begin
    if (!arst && valid_o && ready_i) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed=%0h expected=none", flit_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("flit_data", 64'(flit_data_o), 64'(e.data));
        chk("flit_vc", 64'(vc_id_o), 64'(e.vc));
      end
    end
  end

  task automatic send_msg(input logic [X_WIDTH-1:0] x, input logic [Y_WIDTH-1:0] y,
                          input logic [PKT_WIDTH-1:0] len, input logic [VC_WIDTH-1:0] vc);
    int n;
    msg_valid_i  = 1'b1;
    msg_x_dest_i = x;
    msg_y_dest_i = y;
    msg_len_i    = len;
    msg_vc_i     = vc;
    cur_vc       = vc;
    exp_q.push_back('{data: mk_head(x, y, len), vc: vc});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!msg_ready_o && n < 50);
    chk("msg_accept", 64'(msg_ready_o), 64'd1);
    @(posedge clk);
    #1 msg_valid_i = 1'b0;
  endtask

  task automatic send_pld(input logic [1:0] t, input logic [FW-3:0] d);
    int n;
    pld_valid_i = 1'b1;
    pld_data_i  = d;
    exp_q.push_back('{data: mk_body(t, d), vc: cur_vc});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pld_ready_o && n < 50);
    chk("pld_accept", 64'(pld_ready_o), 64'd1);
    @(posedge clk);
    #1 pld_valid_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_flit"}, 64'(flit_data_o), 64'd0);
    chk({tag, "_vc"}, 64'(vc_id_o), 64'd0);
    chk({tag, "_msg_ready"}, 64'(msg_ready_o), 64'd1);
    chk({tag, "_pld_ready"}, 64'(pld_ready_o), 64'd0);
`ifdef RAVENOC_PKT_TX_CNT_EN
    chk({tag, "_cnt"}, 64'(pkt_cnt_o), 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    msg_valid_i = 1'b0; msg_x_dest_i = '0; msg_y_dest_i = '0; msg_len_i = '0; msg_vc_i = '0;
    pld_valid_i = 1'b0; pld_data_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    arst = 1'b0;
    @(posedge clk);
    #1;

    // Zero-length packet: single HEAD_TAIL flit
    send_msg(2'd1, 2'd0, 8'd0, 2'd2);
    chk("zl_valid", 64'(valid_o), 64'd1);
    chk("zl_type", 64'(flit_data_o[FW-1:FW-2]), 64'd3);
    chk("zl_vc", 64'(vc_id_o), 64'd2);
    @(posedge clk);
    #1;
    chk("zl_valid_clear", 64'(valid_o), 64'd0);
`ifdef RAVENOC_PKT_TX_CNT_EN
    chk("zl_cnt", 64'(pkt_cnt_o), 64'd1);
`endif

    // Three-payload packet at full rate
    hs_cyc.delete();
    send_msg(2'd2, 2'd3, 8'd3, 2'd1);
    send_pld(2'b01, 32'hA);
    chk("body_msg_ready0", 64'(msg_ready_o), 64'd0);
    send_pld(2'b01, 32'hB);
    chk("body_msg_ready1", 64'(msg_ready_o), 64'd0);
    send_pld(2'b10, 32'hC);
    repeat (2) @(posedge clk);
    #1;
    chk("p3_flits", 64'(hs_cyc.size()), 64'd4);
    chk("p3_span", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);
`ifdef RAVENOC_PKT_TX_CNT_EN
    chk("p3_cnt", 64'(pkt_cnt_o), 64'd2);
`endif

    // Backpressure on the second flit for 5 cycles
    hs_cyc.delete();
    send_msg(2'd0, 2'd1, 8'd2, 2'd3);
    send_pld(2'b01, 32'h11);
    ready_i     = 1'b0;
    pld_valid_i = 1'b1;
    pld_data_i  = 32'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(valid_o), 64'd1);
      chk("stall_flit", 64'(flit_data_o), 64'(mk_body(2'b01, 32'h11)));
      chk("stall_vc", 64'(vc_id_o), 64'd3);
      chk("stall_pld_ready", 64'(pld_ready_o), 64'd0);
      chk("stall_msg_ready", 64'(msg_ready_o), 64'd0);
    end
    @(posedge clk);
    #1 ready_i = 1'b1;
    pld_valid_i = 1'b0;
    send_pld(2'b10, 32'h22);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_flits", 64'(hs_cyc.size()), 64'd3);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back single-payload packets with no bubble
    hs_cyc.delete();
    send_msg(2'd3, 2'd2, 8'd1, 2'd0);
    send_pld(2'b10, 32'h1);
    send_msg(2'd1, 2'd1, 8'd1, 2'd1);
    send_pld(2'b10, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_flits", 64'(hs_cyc.size()), 64'd4);
    chk("b2b_span", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);

    // Reset in the middle of a 4-payload packet
    send_msg(2'd2, 2'd2, 8'd4, 2'd2);
    send_pld(2'b01, 32'h101);
    send_pld(2'b01, 32'h102);
    arst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_reset_outputs("midpkt_reset");
    @(posedge clk);
    #1 arst = 1'b0;
    hs_cyc.delete();
    send_msg(2'd1, 2'd2, 8'd0, 2'd1);
    chk("post_reset_type", 64'(flit_data_o[FW-1:FW-2]), 64'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_flits", 64'(hs_cyc.size()), 64'd1);
`ifdef RAVENOC_PKT_TX_CNT_EN
    chk("post_reset_cnt", 64'(pkt_cnt_o), 64'd1);

    // Counter wrap from all-ones
    @(negedge clk);
    force dut.pkt_cnt_o = 32'hFFFF_FFFF;
    #1 release dut.pkt_cnt_o;
    chk("cnt_preload", 64'(pkt_cnt_o), 64'hFFFF_FFFF);
    @(posedge clk);
    #1;
    send_msg(2'd0, 2'd0, 8'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("cnt_wrap", 64'(pkt_cnt_o), 64'd0);
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
